register_file_32x32: RTL and testbench
======================================

Name: register_file_32x32

Overview:
- General-purpose CPU register file: 32 registers of N bits, two asynchronous read ports, one synchronous write port.
- Sits in the decode stage of the single-cycle/pipelined datapath.
- Read ports feed the ALU operand path; the write port receives the writeback result.
- Register 0 is hardwired to zero (MIPS convention).

Parameters:
- N, 32, data width of each register and of all data ports.

Ports:
- clk  input  1  system clock; all writes occur on its rising edge.
- reset  input  1  asynchronous, active-low; clears all registers.
- Reg_Write_i  input  1  write enable; write occurs at rising clk edge when 1.
- Write_Register_i  input  5  destination register index 0..31.
- Read_Register_1_i  input  5  read port 1 register index.
- Read_Register_2_i  input  5  read port 2 register index.
- Write_Data_i  input  N  data to write.
- Read_Data_1_i  output  N  contents of register Read_Register_1_i. The _i suffix is the established port name; the port is an output.
- Read_Data_2_i  output  N  contents of register Read_Register_2_i. The _i suffix is the established port name; the port is an output.

Behaviour:
- Storage: registers R0..R31, each N bits.
- Reset:
  - reset=0 asynchronously forces R0..R31 to 0, independent of clk.
  - Both read outputs therefore read 0 while reset is low.
  - Reset dominates any write on the same edge.
- Write:
  - On rising clk with reset=1 and Reg_Write_i=1, R[Write_Register_i] <= Write_Data_i.
  - Reg_Write_i=0: no register changes.
  - Only the addressed register changes; all others hold.
- Register 0:
  - Writes to index 0 are ignored.
  - R0 always reads 0.
- Read:
  - Purely combinational.
  - Read_Data_1_i = R[Read_Register_1_i] and Read_Data_2_i = R[Read_Register_2_i], zero-latency from address change.
  - Both ports may address the same register simultaneously, and both return the same value.
- Read during write, same index:
  - Before the rising edge, the output shows the old value.
  - The new value appears immediately after the edge.
  - No internal write-to-read bypass.
- Write inputs (index, data) only matter at the rising edge; changes between edges have no effect.
- No X propagation: every register has a defined reset value, and all 32 indices are valid.

Test Plan:
- Reset: hold reset=0 for 5 time units with random read addresses -> both outputs 0. Release reset -> outputs stay 0 until a write occurs.
- Write R0: Reg_Write_i=1, Write_Register_i=0, Write_Data_i=3, several edges; read port 1 at index 0 -> Read_Data_1_i=0.
- Write disabled: Reg_Write_i=0, Write_Register_i=1, Write_Data_i=5, several edges -> read R1 = 0.
- Sequential writes, each held ≥1 edge with Reg_Write_i=1: R1=5, R2=15, R3=25, R4=50.
  - Port1 reading 1 then 3 -> 5 then 25.
  - Port2 reading 2, 4, 1, 3 -> 15, 50, 5, 25.
  - Port1 reading 10 or 12 (never written) -> 0.
- Read-during-write: port1 addresses R2 (holding 15) while writing R2=0xAAAA5555 -> output 15 before the edge, 0xAAAA5555 after.
  - The same case checks both ports on the same index: they show identical values.
- Async reset mid-operation: with R1..R4 loaded, drive reset=0 between clock edges -> all reads immediately 0. Then release reset and write R5=7 -> R5=7 and R1..R4 still 0.

Source files
------------

// File: rtl/register_file_32x32_if.sv
// Register-file access bundle: one synchronous write port and two combinational read ports.
// Write contract: Reg_Write_i, Write_Register_i and Write_Data_i are sampled only on the rising clk edge.
interface register_file_32x32_if #(
    parameter int N = 32
);
    logic         Reg_Write_i;
    logic [4:0]   Write_Register_i;
    logic [4:0]   Read_Register_1_i;
    logic [4:0]   Read_Register_2_i;
    logic [N-1:0] Write_Data_i;
    logic [N-1:0] Read_Data_1_i;
    logic [N-1:0] Read_Data_2_i;

    modport master (
        output Reg_Write_i,
        output Write_Register_i,
        output Read_Register_1_i,
        output Read_Register_2_i,
        output Write_Data_i,
        input  Read_Data_1_i,
        input  Read_Data_2_i
    );

    modport slave (
        input  Reg_Write_i,
        input  Write_Register_i,
        input  Read_Register_1_i,
        input  Read_Register_2_i,
        input  Write_Data_i,
        output Read_Data_1_i,
        output Read_Data_2_i
    );
endinterface

// File: rtl/register_file_32x32.sv
// 32 x N register file: R0 hardwired to zero, asynchronous active-low clear,
// synchronous write, two combinational read ports with no write-to-read bypass.
module register_file_32x32 #(
    parameter int N = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    register_file_32x32_if.slave rf
);

    // R0 has no storage; only R1..R31 are real flops.
    logic [N-1:0] regs [1:31];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 1; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (rf.Reg_Write_i && (rf.Write_Register_i != 5'd0)) begin
            regs[rf.Write_Register_i] <= rf.Write_Data_i;
        end
    end

    // Reads see the stored value only, so a same-cycle write shows up after the edge.
    assign rf.Read_Data_1_i = (rf.Read_Register_1_i == 5'd0) ? '0 : regs[rf.Read_Register_1_i];
    assign rf.Read_Data_2_i = (rf.Read_Register_2_i == 5'd0) ? '0 : regs[rf.Read_Register_2_i];

endmodule

// File: tb/tb_register_file_32x32.sv
// Randomized bench for register_file_32x32: the driver pushes expected reads from an
// array model into a queue, and a negedge monitor pops and compares them.
module tb_register_file_32x32;
    localparam int N = 32;

    logic clk;
    logic reset;

    register_file_32x32_if #(.N(N)) rf ();

    register_file_32x32 #(.N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .rf    (rf.slave)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model and scoreboard
    logic [N-1:0] model [32];
    logic [N-1:0] exp_q [$];
    int           addr_q [$];
    logic         chk_valid;
    int           vectors;
    int           miscompares;

    // Drive one cycle starting just after a rising edge. Expected reads come from the model
    // state before the coming edge; the model write is applied once that edge has passed.
    task automatic step(input logic rst, input logic we, input logic [4:0] wa,
                        input logic [N-1:0] wd, input logic [4:0] ra1,
                        input logic [4:0] ra2, input logic chk);
        reset                = rst;
        rf.Reg_Write_i       = we;
        rf.Write_Register_i  = wa;
        rf.Write_Data_i      = wd;
        rf.Read_Register_1_i = ra1;
        rf.Read_Register_2_i = ra2;
        if (!rst) begin
            for (int i = 0; i < 32; i++) model[i] = '0;
        end
        if (chk) begin
            exp_q.push_back(model[ra1]);
            addr_q.push_back(int'(ra1));
            exp_q.push_back(model[ra2]);
            addr_q.push_back(int'(ra2));
        end
        chk_valid = chk;
        @(posedge clk);
        if (rst && we && wa != 5'd0) model[wa] = wd;
        #1;
    endtask

    task automatic rd(input logic [4:0] ra1, input logic [4:0] ra2);
        step(1'b1, 1'b0, 5'd0, '0, ra1, ra2, 1'b1);
    endtask

    task automatic wr(input logic [4:0] wa, input logic [N-1:0] wd,
                      input logic [4:0] ra1, input logic [4:0] ra2);
        step(1'b1, 1'b1, wa, wd, ra1, ra2, 1'b1);
    endtask

    // Monitor
    initial begin
        logic [N-1:0] e;
        int           a;
        forever begin
            @(negedge clk);
            if (chk_valid) begin
                if (exp_q.size() < 2) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL scoreboard_underflow got=%0d entries required=2", exp_q.size());
                end else begin
                    e = exp_q.pop_front();
                    a = addr_q.pop_front();
                    vectors++;
                    if (rf.Read_Data_1_i !== e) begin
                        miscompares++;
                        $display("FAIL rd1 addr=%0d got=%h exp=%h", a, rf.Read_Data_1_i, e);
                    end
                    e = exp_q.pop_front();
                    a = addr_q.pop_front();
                    vectors++;
                    if (rf.Read_Data_2_i !== e) begin
                        miscompares++;
                        $display("FAIL rd2 addr=%0d got=%h exp=%h", a, rf.Read_Data_2_i, e);
                    end
                end
            end
        end
    end

    // Driver
    initial begin
        logic [4:0]   ra;
        logic [4:0]   rb;
        logic [4:0]   wa;
        logic [N-1:0] wd;
        vectors     = 0;
        miscompares = 0;
        chk_valid   = 1'b0;
        reset       = 1'b0;
        rf.Reg_Write_i       = 1'b0;
        rf.Write_Register_i  = '0;
        rf.Write_Data_i      = '0;
        rf.Read_Register_1_i = '0;
        rf.Read_Register_2_i = '0;
        for (int i = 0; i < 32; i++) model[i] = '0;
        @(posedge clk);
        #1;

        // Reset held low with random reads, and a write attempted under reset
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 5'(1 + i), 32'hDEAD_BEEF,
                 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 1'b1);
        end
        for (int i = 0; i < 2; i++) rd(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));

        // Writes to R0 are ignored
        for (int i = 0; i < 3; i++) wr(5'd0, 32'd3, 5'd0, 5'd0);
        rd(5'd0, 5'd0);

        // Write enable low leaves R1 alone
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 5'd1, 32'd5, 5'd1, 5'd1, 1'b1);

        // Sequential writes and reads on both ports
        wr(5'd1, 32'd5, 5'd1, 5'd0);
        wr(5'd2, 32'd15, 5'd1, 5'd1);
        wr(5'd3, 32'd25, 5'd2, 5'd1);
        wr(5'd4, 32'd50, 5'd3, 5'd2);
        rd(5'd1, 5'd2);
        rd(5'd3, 5'd4);
        rd(5'd10, 5'd1);
        rd(5'd12, 5'd3);

        // Read during write on the same index: old value before the edge, new after
        wr(5'd2, 32'hAAAA_5555, 5'd2, 5'd2);
        rd(5'd2, 5'd2);

        // Async reset between edges, then resume
        step(1'b0, 1'b0, 5'd0, '0, 5'd1, 5'd2, 1'b1);
        step(1'b0, 1'b0, 5'd0, '0, 5'd3, 5'd4, 1'b1);
        wr(5'd5, 32'd7, 5'd1, 5'd2);
        rd(5'd5, 5'd3);
        rd(5'd4, 5'd1);

        // Random traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            wa = 5'($urandom_range(0, 31));
            wd = $urandom();
            if ($urandom_range(0, 3) == 0) wd = (wd[0]) ? '1 : '0;
            ra = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
            rb = ($urandom_range(0, 3) == 0) ? ra : 5'($urandom_range(0, 31));
            step(($urandom_range(0, 59) != 0), ($urandom_range(0, 2) != 0), wa, wd, ra, rb, 1'b1);
        end

        step(1'b1, 1'b0, 5'd0, '0, 5'd0, 5'd0, 1'b0);
        step(1'b1, 1'b0, 5'd0, '0, 5'd0, 5'd0, 1'b0);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain got=%0d entries required=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
